// File: rtl/seg_pkg.sv
// Shared definitions for the paged 7-segment display driver.
//   page_state_e       : page FSM states (BLANK separator page, DATA pages)
//   BLANK_CODE_DEFAULT : BCD code the downstream decoder renders as dark
//   pages(n, d)        : ceil(n / d), number of pages needed for n digits
package seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DATA  = 1'b1
   } page_state_e;

   localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hF;

   function automatic int unsigned pages(input int unsigned n, input int unsigned d);
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/seg_page_scroller_tick_gen.sv
// Page-step tick generator on the system clock domain.
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high reset (counter to 0)
//   tick     : one-cycle pulse when the counter is at TICK_DIV-1
module tick_gen #(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic CLOCK_50,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seg_page_scroller.sv
// Paged display driver for an N-digit BCD value on a bank of 7-segment
// displays. Snapshots bcd_in once per frame, shows the pages most
// significant first, then a blank separator page.
//   CLOCK_50    : system clock
//   reset       : synchronous, active-high reset
//   bcd_in      : BCD value, digit 0 in [3:0]
//   hold        : freezes page stepping (ticks arriving while high are lost)
//   lz_suppress : show leading zeros as BLANK_CODE
//   skip_lead   : with lz_suppress, start the frame at the first non-blank page
//   disp_bcd    : digits of the current page, display 0 in [3:0]
//   page_idx    : current page, PAGES means the blank page
//   frame_start : one-cycle pulse on entry to the first data page of a frame
module seg_page_scroller
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 9,
   parameter int unsigned DISP_DIGITS = 3,
   parameter int unsigned TICK_DIV    = 25_000_000,
   parameter logic [3:0]  BLANK_CODE  = BLANK_CODE_DEFAULT,
   localparam int unsigned PAGES = pages(NUM_DIGITS, DISP_DIGITS),
   localparam int unsigned PW    = $clog2(PAGES + 1)
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic [4*NUM_DIGITS-1:0]  bcd_in,
   input  logic                     hold,
   input  logic                     lz_suppress,
   input  logic                     skip_lead,
   output logic [4*DISP_DIGITS-1:0] disp_bcd,
   output logic [PW-1:0]            page_idx,
   output logic                     frame_start
);

   localparam int unsigned DW = $clog2(NUM_DIGITS + 1);

   logic                     tick;
   page_state_e              state;
   page_state_e              state_next;
   logic [PW-1:0]            page_next;
   logic                     snap_load;
   logic                     frame_start_next;
   logic [4*NUM_DIGITS-1:0]  snap;
   logic [PW-1:0]            lead_page;
   logic [PW-1:0]            start_page;
   logic [DW-1:0]            snap_top;
   logic [NUM_DIGITS-1:0]    shown;
   logic [4*DISP_DIGITS-1:0] disp_next;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .tick     (tick)
   );

   // Start page is taken from the value being captured, so the skip
   // decision always matches the snapshot it is applied to.
   always_comb begin
      lead_page = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_in[4*i +: 4] != 4'd0) begin
            lead_page = PW'(i / DISP_DIGITS);
         end
      end
      start_page = (lz_suppress && skip_lead) ? lead_page : PW'(PAGES - 1);
   end

   // Priority scan for the highest non-zero snapshot digit; everything above
   // it is suppressed. snap_top defaults to 0 so digit 0 always shows.
   always_comb begin
      snap_top = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (snap[4*i +: 4] != 4'd0) begin
            snap_top = DW'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         shown[i] = !lz_suppress || (DW'(i) <= snap_top);
      end
   end

   always_comb begin
      state_next       = state;
      page_next        = page_idx;
      snap_load        = 1'b0;
      frame_start_next = 1'b0;
      if (tick && !hold) begin
         unique case (state)
            BLANK: begin
               state_next       = DATA;
               page_next        = start_page;
               snap_load        = 1'b1;
               frame_start_next = 1'b1;
            end
            DATA: begin
               if (page_idx == '0) begin
                  state_next = BLANK;
                  page_next  = PW'(PAGES);
               end else begin
                  page_next = page_idx - PW'(1);
               end
            end
         endcase
      end
   end

   // Page mux; slots past NUM_DIGITS on the top page stay blank.
   always_comb begin
      disp_next = {DISP_DIGITS{BLANK_CODE}};
      if (state == DATA) begin
         for (int unsigned p = 0; p < PAGES; p++) begin
            if (page_idx == PW'(p)) begin
               for (int unsigned d = 0; d < DISP_DIGITS; d++) begin
                  if (p * DISP_DIGITS + d < NUM_DIGITS) begin
                     disp_next[4*d +: 4] = shown[p*DISP_DIGITS + d] ?
                                           snap[4*(p*DISP_DIGITS + d) +: 4] :
                                           BLANK_CODE;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= BLANK;
         page_idx    <= PW'(PAGES);
         snap        <= '0;
         disp_bcd    <= {DISP_DIGITS{BLANK_CODE}};
         frame_start <= 1'b0;
      end else begin
         state       <= state_next;
         page_idx    <= page_next;
         if (snap_load) begin
            snap <= bcd_in;
         end
         disp_bcd    <= disp_next;
         frame_start <= frame_start_next;
      end
   end

endmodule
